// File: rtl/writeback_unit_pkg.sv
// Shared types and constants for the writeback stage: FSM state encoding
// and the load funct3 codes understood by the load extender.
package writeback_unit_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_MEM = 2'd1,
      ERR      = 2'd2
   } wb_state_e;

   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LD  = 3'b011;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;
   localparam logic [2:0] LWU = 3'b110;

endpackage

// File: rtl/writeback_unit_load_extend.sv
// wb_load_extend: combinational alignment and sign/zero extension of raw
// load data from a naturally aligned word/dword bus.
module wb_load_extend
   import writeback_unit_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0]            rdata_i,
   input  logic [2:0]                 funct3_i,
   input  logic [$clog2(XLEN/8)-1:0]  addr_lo_i,
   output logic [XLEN-1:0]            data_o
);

   localparam int AW = $clog2(XLEN/8);
   localparam logic [AW-1:0] H_MASK = ~AW'(1);
   localparam logic [AW-1:0] W_MASK = ~AW'(3);

   logic [AW-1:0] addr_h;
   logic [AW-1:0] addr_w;
   logic [7:0]    byte_v;
   logic [15:0]   half_v;
   logic [31:0]   word_v;

   // Half and word lanes ignore the low offset bits below their size.
   assign addr_h = addr_lo_i & H_MASK;
   assign addr_w = addr_lo_i & W_MASK;

   assign byte_v = 8'(rdata_i >> {addr_lo_i, 3'b000});
   assign half_v = 16'(rdata_i >> {addr_h, 3'b000});
   assign word_v = 32'(rdata_i >> {addr_w, 3'b000});

   always_comb begin
      data_o = rdata_i;
      case (funct3_i)
         LB:  data_o = XLEN'($signed(byte_v));
         LBU: data_o = XLEN'(byte_v);
         LH:  data_o = XLEN'($signed(half_v));
         LHU: data_o = XLEN'(half_v);
         LW:  data_o = XLEN'($signed(word_v));
         LWU: if (XLEN == 64) data_o = XLEN'(word_v);
         default: data_o = rdata_i;
      endcase
   end

endmodule

// File: rtl/writeback_unit.sv
// Final pipeline stage: retires one instruction per cycle into the register
// file, waiting (with timeout) for variable-latency load data.
// Build option: WB_LOAD_ALIGN_EN enables sub-word load alignment/extension.
module writeback_unit
   import writeback_unit_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5,
   parameter int MAX_WAIT   = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       valid_i,
   output logic                       ready_o,
   input  logic [REG_ADDR_W-1:0]      sel_rd_i,
   input  logic                       rd_we_i,
   input  logic                       mem_re_i,
   input  logic [2:0]                 funct3_i,
   input  logic [$clog2(XLEN/8)-1:0]  addr_lo_i,
   input  logic [XLEN-1:0]            alu_result_i,
   input  logic                       mem_rvalid_i,
   input  logic [XLEN-1:0]            mem_rdata_i,
   output logic                       rf_we_o,
   output logic [REG_ADDR_W-1:0]      rf_sel_rd_o,
   output logic [XLEN-1:0]            rf_data_o,
   output logic                       err_o
);

   localparam int AW    = $clog2(XLEN/8);
   localparam int CNT_W = $clog2(MAX_WAIT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

   wb_state_e             state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [REG_ADDR_W-1:0] pend_rd_q, pend_rd_d;
   logic                  pend_we_q, pend_we_d;
   logic                  rf_we_q, rf_we_d;
   logic [REG_ADDR_W-1:0] rf_sel_rd_q, rf_sel_rd_d;
   logic [XLEN-1:0]       rf_data_q, rf_data_d;
   logic                  err_q, err_d;
   logic                  capture;
   logic [XLEN-1:0]       ld_data;

`ifdef WB_LOAD_ALIGN_EN
   logic [2:0]    pend_f3_q, pend_f3_d;
   logic [AW-1:0] pend_lo_q, pend_lo_d;
   logic [2:0]    ext_f3;
   logic [AW-1:0] ext_lo;

   assign pend_f3_d = capture ? funct3_i  : pend_f3_q;
   assign pend_lo_d = capture ? addr_lo_i : pend_lo_q;

   // A pending load is extended with its captured size/offset, not the
   // (possibly unrelated) values now on the input bus.
   assign ext_f3 = (state_q == WAIT_MEM) ? pend_f3_q : funct3_i;
   assign ext_lo = (state_q == WAIT_MEM) ? pend_lo_q : addr_lo_i;

   always_ff @(posedge clk) begin
      if (rst) begin
         pend_f3_q <= '0;
         pend_lo_q <= '0;
      end else begin
         pend_f3_q <= pend_f3_d;
         pend_lo_q <= pend_lo_d;
      end
   end

   wb_load_extend #(
      .XLEN (XLEN)
   ) u_load_extend (
      .rdata_i   (mem_rdata_i),
      .funct3_i  (ext_f3),
      .addr_lo_i (ext_lo),
      .data_o    (ld_data)
   );
`else
   logic unused_align;
   assign unused_align = ^{funct3_i, addr_lo_i};
   assign ld_data      = mem_rdata_i;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (valid_i && mem_re_i && !mem_rvalid_i) state_d = WAIT_MEM;
         end
         WAIT_MEM: begin
            // rvalid takes priority over the timeout on the last wait cycle
            if (mem_rvalid_i)           state_d = IDLE;
            else if (cnt_q == CNT_LAST) state_d = ERR;
         end
         ERR:     state_d = ERR;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ready_o     = 1'b0;
      capture     = 1'b0;
      cnt_d       = cnt_q;
      pend_rd_d   = pend_rd_q;
      pend_we_d   = pend_we_q;
      rf_we_d     = 1'b0;
      rf_sel_rd_d = rf_sel_rd_q;
      rf_data_d   = rf_data_q;
      err_d       = err_q;
      case (state_q)
         IDLE: begin
            ready_o = 1'b1;
            if (valid_i) begin
               if (!mem_re_i || mem_rvalid_i) begin
                  rf_we_d     = rd_we_i && (sel_rd_i != '0);
                  rf_sel_rd_d = sel_rd_i;
                  rf_data_d   = mem_re_i ? ld_data : alu_result_i;
               end else begin
                  capture   = 1'b1;
                  pend_rd_d = sel_rd_i;
                  pend_we_d = rd_we_i;
                  cnt_d     = '0;
               end
            end
         end
         WAIT_MEM: begin
            if (mem_rvalid_i) begin
               rf_we_d     = pend_we_q && (pend_rd_q != '0);
               rf_sel_rd_d = pend_rd_q;
               rf_data_d   = ld_data;
            end else if (cnt_q == CNT_LAST) begin
               err_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q       <= '0;
         pend_rd_q   <= '0;
         pend_we_q   <= 1'b0;
         rf_we_q     <= 1'b0;
         rf_sel_rd_q <= '0;
         rf_data_q   <= '0;
         err_q       <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         pend_rd_q   <= pend_rd_d;
         pend_we_q   <= pend_we_d;
         rf_we_q     <= rf_we_d;
         rf_sel_rd_q <= rf_sel_rd_d;
         rf_data_q   <= rf_data_d;
         err_q       <= err_d;
      end
   end

   assign rf_we_o     = rf_we_q;
   assign rf_sel_rd_o = rf_sel_rd_q;
   assign rf_data_o   = rf_data_q;
   assign err_o       = err_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit (XLEN=32, MAX_WAIT=4); expected
// register-file updates are queued with the cycle they must appear in.
module tb_writeback_unit;
   import writeback_unit_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_i;
   logic        ready_o;
   logic [4:0]  sel_rd_i;
   logic        rd_we_i;
   logic        mem_re_i;
   logic [2:0]  funct3_i;
   logic [1:0]  addr_lo_i;
   logic [31:0] alu_result_i;
   logic        mem_rvalid_i;
   logic [31:0] mem_rdata_i;
   logic        rf_we_o;
   logic [4:0]  rf_sel_rd_o;
   logic [31:0] rf_data_o;
   logic        err_o;

   typedef struct {
      int          cyc;
      logic        we;
      logic [4:0]  rd;
      logic [31:0] data;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   writeback_unit #(
      .XLEN       (32),
      .REG_ADDR_W (5),
      .MAX_WAIT   (4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .valid_i      (valid_i),
      .ready_o      (ready_o),
      .sel_rd_i     (sel_rd_i),
      .rd_we_i      (rd_we_i),
      .mem_re_i     (mem_re_i),
      .funct3_i     (funct3_i),
      .addr_lo_i    (addr_lo_i),
      .alu_result_i (alu_result_i),
      .mem_rvalid_i (mem_rvalid_i),
      .mem_rdata_i  (mem_rdata_i),
      .rf_we_o      (rf_we_o),
      .rf_sel_rd_o  (rf_sel_rd_o),
      .rf_data_o    (rf_data_o),
      .err_o        (err_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [31:0] ext_model(input logic [2:0] f3, input logic [1:0] lo,
                                             input logic [31:0] rd);
`ifdef WB_LOAD_ALIGN_EN
      logic [7:0]  b;
      logic [15:0] h;
      b = rd[int'(lo)*8 +: 8];
      h = lo[1] ? rd[31:16] : rd[15:0];
      case (f3)
         3'b000:  return {{24{b[7]}}, b};
         3'b100:  return {24'h0, b};
         3'b001:  return {{16{h[15]}}, h};
         3'b101:  return {16'h0, h};
         default: return rd;
      endcase
`else
      return rd;
`endif
   endfunction

   always @(negedge clk) begin
      if (!rst) begin
         while (sb.size() > 0 && sb[0].cyc < cyc) begin
            chk("sb_missed", 64'(sb[0].cyc), 64'(cyc));
            void'(sb.pop_front());
         end
         if (sb.size() > 0 && sb[0].cyc == cyc) begin
            exp_t e;
            e = sb.pop_front();
            chk("rf_we", rf_we_o, e.we);
            chk("rf_rd", rf_sel_rd_o, e.rd);
            chk("rf_data", rf_data_o, e.data);
         end else begin
            chk("idle_we", rf_we_o, 1'b0);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      valid_i      = 1'b0;
      mem_re_i     = 1'b0;
      mem_rvalid_i = 1'b0;
      rd_we_i      = 1'b0;
   endtask

   task automatic drive(input logic load, input logic [2:0] f3, input logic [1:0] lo,
                        input logic [4:0] rd, input logic we, input logic [31:0] alu,
                        input logic rv, input logic [31:0] rdata);
      exp_t e;
      valid_i      = 1'b1;
      mem_re_i     = load;
      funct3_i     = f3;
      addr_lo_i    = lo;
      sel_rd_i     = rd;
      rd_we_i      = we;
      alu_result_i = alu;
      mem_rvalid_i = rv;
      mem_rdata_i  = rdata;
      if (!load || rv) begin
         e.cyc  = cyc + 1;
         e.we   = we && (rd != 5'd0);
         e.rd   = rd;
         e.data = load ? ext_model(f3, lo, rdata) : alu;
         sb.push_back(e);
      end
      tick();
      idle_inputs();
   endtask

   task automatic complete(input logic [2:0] f3, input logic [1:0] lo, input logic [4:0] rd,
                           input logic we, input logic [31:0] rdata);
      exp_t e;
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = rdata;
      funct3_i     = 3'b111;
      addr_lo_i    = 2'd1;
      e.cyc  = cyc + 1;
      e.we   = we && (rd != 5'd0);
      e.rd   = rd;
      e.data = ext_model(f3, lo, rdata);
      sb.push_back(e);
      tick();
      idle_inputs();
   endtask

   initial begin
      rst          = 1'b1;
      funct3_i     = 3'b000;
      addr_lo_i    = 2'd0;
      sel_rd_i     = 5'd0;
      alu_result_i = 32'h0;
      mem_rdata_i  = 32'h0;
      idle_inputs();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_ready", ready_o, 1'b1);
      chk("rst_err", err_o, 1'b0);
      chk("rst_rd", rf_sel_rd_o, 5'd0);
      chk("rst_data", rf_data_o, 32'h0);

      drive(1'b0, 3'b000, 2'd0, 5'd5, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0);
      tick();
      drive(1'b0, 3'b000, 2'd0, 5'd0, 1'b1, 32'h12345678, 1'b0, 32'h0);
      drive(1'b0, 3'b000, 2'd0, 5'd3, 1'b0, 32'hCAFEF00D, 1'b0, 32'h0);
      tick();

      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'hFFFF_FFFF;
      tick();
      idle_inputs();
      chk("stray_rv_ready", ready_o, 1'b1);

      drive(1'b1, LB, 2'd2, 5'd7, 1'b1, 32'h0, 1'b0, 32'h0);
      chk("lb_ready0", ready_o, 1'b0);
      tick();
      chk("lb_ready1", ready_o, 1'b0);
      tick();
      chk("lb_ready2", ready_o, 1'b0);
      complete(LB, 2'd2, 5'd7, 1'b1, 32'h0080FF00);
      chk("lb_ready_back", ready_o, 1'b1);

      drive(1'b1, LBU, 2'd2, 5'd8, 1'b1, 32'h0, 1'b0, 32'h0);
      tick();
      tick();
      complete(LBU, 2'd2, 5'd8, 1'b1, 32'h0080FF00);

      drive(1'b1, LH, 2'd2, 5'd10, 1'b1, 32'h0, 1'b1, 32'h8001_1234);
      drive(1'b1, LHU, 2'd0, 5'd11, 1'b1, 32'h0, 1'b1, 32'h8001_9234);
      drive(1'b1, LB, 2'd1, 5'd12, 1'b1, 32'h0, 1'b1, 32'h0000_7F00);
      drive(1'b1, LW, 2'd0, 5'd13, 1'b1, 32'h0, 1'b1, 32'h8765_4321);
      drive(1'b1, 3'b110, 2'd3, 5'd14, 1'b1, 32'h0, 1'b1, 32'h89AB_CDEF);
      tick();

      drive(1'b1, LW, 2'd0, 5'd11, 1'b1, 32'h0, 1'b0, 32'h0);
      repeat (3) tick();
      chk("edge_ready", ready_o, 1'b0);
      complete(LW, 2'd0, 5'd11, 1'b1, 32'hA5A5_5A5A);
      chk("edge_err", err_o, 1'b0);
      chk("edge_ready_back", ready_o, 1'b1);

      drive(1'b1, LH, 2'd0, 5'd15, 1'b1, 32'h0, 1'b0, 32'h0);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_rst_rd", rf_sel_rd_o, 5'd0);
      chk("mid_rst_data", rf_data_o, 32'h0);
      chk("mid_rst_ready", ready_o, 1'b1);
      chk("mid_rst_err", err_o, 1'b0);
      tick();

      for (int i = 0; i < 8; i++)
         drive(1'b0, 3'b000, 2'd0, 5'(i + 17), 1'b1, $urandom, 1'b0, 32'h0);
      tick();

      drive(1'b1, LB, 2'd0, 5'd9, 1'b1, 32'h0, 1'b0, 32'h0);
      for (int i = 0; i < 4; i++) begin
         chk("to_err_wait", err_o, 1'b0);
         chk("to_ready_wait", ready_o, 1'b0);
         tick();
      end
      chk("to_err", err_o, 1'b1);
      chk("to_ready", ready_o, 1'b0);
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'h1111_2222;
      valid_i      = 1'b1;
      sel_rd_i     = 5'd4;
      rd_we_i      = 1'b1;
      tick();
      idle_inputs();
      tick();
      chk("err_sticky", err_o, 1'b1);
      chk("err_ready", ready_o, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("err_cleared", err_o, 1'b0);
      chk("err_rst_ready", ready_o, 1'b1);

      drive(1'b0, 3'b000, 2'd0, 5'd6, 1'b1, 32'h0BAD_CAFE, 1'b0, 32'h0);
      repeat (3) tick();
      chk("sb_drain", 64'(sb.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/writeback_unit.md
# writeback_unit

Parametrised final pipeline stage: accepts one retiring instruction per cycle from the memory stage over a valid/ready handshake and writes its result (ALU result or load data) into the register file one cycle later. Variable-latency load responses are waited for by a small FSM with a timeout. Sub-word loads are aligned and sign/zero-extended. Writes to x0 and to instructions that do not write rd are suppressed.

## Interface
Parameters:
- XLEN, 32, datapath width; 32 or 64 only
- REG_ADDR_W, 5, register index width (4 for RV32E)
- MAX_WAIT, 16, max cycles a load may wait for mem_rvalid_i; ≥1

Ports:
- clk  in  1  clock; single clock domain
- rst  in  1  synchronous, active-high reset
- valid_i  in  1  instruction presented by memory stage
- ready_o  out  1  stage can accept; handshake completes on valid_i && ready_o
- sel_rd_i  in  REG_ADDR_W  destination register
- rd_we_i  in  1  instruction writes rd
- mem_re_i  in  1  instruction is a load
- funct3_i  in  3  load size/sign
- addr_lo_i  in  $clog2(XLEN/8)  load byte offset
- alu_result_i  in  XLEN  non-load result
- mem_rvalid_i  in  1  load data valid this cycle
- mem_rdata_i  in  XLEN  raw load data (naturally aligned word/dword)
- rf_we_o  out  1  register-file write enable, single-cycle pulse
- rf_sel_rd_o  out  REG_ADDR_W  write index
- rf_data_o  out  XLEN  write data
- err_o  out  1  sticky load-timeout error

## Operation
- States: IDLE, WAIT_MEM, ERR. ready_o = (state == IDLE).
- IDLE, accepted non-load: next cycle rf_we_o = rd_we_i && sel_rd_i != 0, rf_sel_rd_o = sel_rd_i, rf_data_o = alu_result_i.
- IDLE, accepted load with mem_rvalid_i the same cycle: as above, with data = extend(mem_rdata_i). State stays IDLE.
- IDLE, accepted load without mem_rvalid_i: capture sel_rd, rd_we, funct3, addr_lo; clear wait counter; go to WAIT_MEM.
- WAIT_MEM: counter +1 per cycle. On mem_rvalid_i, write captured rd with extended data next cycle and return to IDLE. If the counter reaches MAX_WAIT−1 without rvalid, go to ERR, set err_o, and perform no write. Simultaneous rvalid and timeout: rvalid wins.
- ERR: ready_o = 0; left only by rst.
- mem_rvalid_i with no load pending is ignored. valid_i while ready_o = 0 is ignored; upstream holds.
- Extension (XLEN=32): 000 LB and 100 LBU use byte addr_lo; 001 LH and 101 LHU use half addr_lo[1]; 010 LW passes the word through; other codes are treated as full-width. XLEN=64 adds 010 LW sign-extend, 110 LWU zero-extend, 011 LD full.
- When rf_we_o = 0, rf_sel_rd_o and rf_data_o still update on every accepted or completed instruction.

## Timing
- Reset: state IDLE, counter 0, rf_we_o 0, rf_sel_rd_o 0, rf_data_o 0, err_o 0. ready_o is 1 in the cycle after reset deasserts.
- Reset during WAIT_MEM discards the pending load; no write occurs.
- Latency: exactly 1 cycle from handshake (or from rvalid for pending loads) to rf outputs.
- Throughput: 1/cycle for non-loads and same-cycle loads. A pending load blocks until completion; ready_o rises the cycle after rvalid.
- rf_we_o is high for one cycle per write. Back-to-back writes keep it high continuously.

## Configuration
- WB_LOAD_ALIGN_EN defined: sub-word alignment and extension as above.
- WB_LOAD_ALIGN_EN undefined: load data is written raw (mem_rdata_i), and funct3_i and addr_lo_i are ignored. All other behaviour is unchanged.

## Structure
- Shared package constants: wb_state_e enum (IDLE, WAIT_MEM, ERR), load funct3 localparams (LB, LH, LW, LBU, LHU, LWU, LD).
- One sub-module, wb_load_extend: combinational (rdata, funct3, addr_lo) → extended XLEN value. It is instantiated only under WB_LOAD_ALIGN_EN.

## Test plan
- Non-load valid, rd=5, alu=0xDEADBEEF, rd_we=1 → next cycle rf_we_o=1, rf_sel_rd_o=5, rf_data_o=0xDEADBEEF; pulse is 1 cycle.
- Non-load rd=0, rd_we=1 → rf_we_o stays 0. Non-load rd=3, rd_we=0 → rf_we_o stays 0.
- Load LB, addr_lo=2, rdata=0x0080FF00, rvalid 3 cycles later → ready_o low for 3 cycles, then rf_data_o=0xFFFFFF80. LBU, same inputs → 0x00000080. Without the macro → 0x0080FF00.
- Load with MAX_WAIT=4, no rvalid → err_o=1 at cycle 4, no write, ready_o stays 0. A later rvalid is ignored. rst clears err_o.
- rvalid on the timeout cycle → write occurs and err_o stays 0. Reset asserted during WAIT_MEM → no write, and all outputs are 0 after reset.
- 8 back-to-back non-loads → rf_we_o high for 8 consecutive cycles with matching rd and data.
